// File: rtl/sync_ctr_shifter.sv
// sync_ctr_shifter: synchronous universal counter / shift register.
//
// Holds a WIDTH-bit state that can hold, count up/down (gated by a cascade
// carry-in), parallel load, shift left/right, rotate left or clear.
// Instances cascade by wiring each stage's cin to the previous stage's cout.
//
// Ports:
//   clk     rising-edge clock
//   nreset  asynchronous active-low reset (q=0, wrap=0)
//   en      clock enable; 0 holds q and clears wrap
//   mode    operation select: 000 hold, 001 inc, 010 dec, 011 load,
//           100 shift left, 101 shift right, 110 rotate left, 111 clear
//   cin     cascade carry/borrow-in; gates inc/dec only
//   d       parallel load data
//   sil     serial input entering bit 0 on shift left
//   sir     serial input entering bit WIDTH-1 on shift right
//   q       current state
//   nq      bitwise complement of q
//   cout    cascade carry/borrow-out (combinational, independent of en)
//   wrap    registered one-cycle pulse after an inc/dec wrap-around
module sync_ctr_shifter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             cin,
  input  logic [WIDTH-1:0] d,
  input  logic             sil,
  input  logic             sir,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic             cout,
  output logic             wrap
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_INC  = 3'b001,
    MODE_DEC  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_SHL  = 3'b100,
    MODE_SHR  = 3'b101,
    MODE_ROL  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;

  mode_e            op;
  logic [WIDTH-1:0] q_next;
  logic             at_max;
  logic             at_min;

  assign op     = mode_e'(mode);
  assign at_max = &q;
  assign at_min = ~|q;
  assign nq     = ~q;

  // Gated by nreset: q is 0 during reset, which would otherwise raise a
  // borrow in dec mode and leak a cascade event out of a held-reset stage.
  always_comb begin
    cout = 1'b0;
    if (nreset && cin) begin
      if ((op == MODE_INC) && at_max) cout = 1'b1;
      if ((op == MODE_DEC) && at_min) cout = 1'b1;
    end
  end

  always_comb begin
    q_next = q;
    case (op)
      MODE_HOLD: q_next = q;
      MODE_INC:  if (cin) q_next = q + WIDTH'(1);
      MODE_DEC:  if (cin) q_next = q - WIDTH'(1);
      MODE_LOAD: q_next = d;
      MODE_SHL:  q_next = {q[WIDTH-2:0], sil};
      MODE_SHR:  q_next = {sir, q[WIDTH-1:1]};
      MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_CLR:  q_next = '0;
      default:   q_next = q;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (en) begin
      q    <= q_next;
      wrap <= cout;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_ctr_shifter.sv
// Scoreboard bench for sync_ctr_shifter: a single 4-bit instance plus a
// cascaded pair of 4-bit instances forming an 8-bit counter. The stimulus
// process drives inputs and pushes the expected outputs for the cycle; the
// monitor pops and compares on each falling edge.
module tb_sync_ctr_shifter;
  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         en = 1'b0;
  logic         cin = 1'b0;
  logic         sil = 1'b0;
  logic         sir = 1'b0;
  logic [2:0]   mode = 3'd0;
  logic [W-1:0] d = '0;
  logic [W-1:0] d_hi = '0;

  logic [W-1:0] q, nq, lo_q, lo_nq, hi_q, hi_nq;
  logic         cout, wrap, lo_cout, lo_wrap, hi_cout, hi_wrap;

  sync_ctr_shifter #(.WIDTH(W)) dut (
    .clk(clk), .nreset(nreset), .en(en), .mode(mode), .cin(cin), .d(d),
    .sil(sil), .sir(sir), .q(q), .nq(nq), .cout(cout), .wrap(wrap)
  );

  sync_ctr_shifter #(.WIDTH(W)) lo (
    .clk(clk), .nreset(nreset), .en(en), .mode(mode), .cin(cin), .d(d),
    .sil(sil), .sir(sir), .q(lo_q), .nq(lo_nq), .cout(lo_cout), .wrap(lo_wrap)
  );

  sync_ctr_shifter #(.WIDTH(W)) hi (
    .clk(clk), .nreset(nreset), .en(en), .mode(mode), .cin(lo_cout), .d(d_hi),
    .sil(sil), .sir(sir), .q(hi_q), .nq(hi_nq), .cout(hi_cout), .wrap(hi_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int q;
    int cout;
    int wrap;
    int cq;
    int cwrap;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int n_step = 0;

  // Reference state: value after the most recent edge.
  int mq = 0, mw = 0, mlo = 0, mhi = 0, mhw = 0;

  function automatic int nxt(int v, int md, int ci, int dv, int si, int sr);
    case (md)
      0: return v;
      1: return ci ? (v + 1) % M : v;
      2: return ci ? (v + M - 1) % M : v;
      3: return dv;
      4: return (v * 2 + si) % M;
      5: return sr * (M / 2) + v / 2;
      6: return (v * 2) % M + v / (M / 2);
      default: return 0;
    endcase
  endfunction

  function automatic int cfun(int v, int md, int ci, int rn);
    if (rn == 0 || ci == 0) return 0;
    if (md == 1 && v == M - 1) return 1;
    if (md == 2 && v == 0) return 1;
    return 0;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, expv);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("q",     e.idx, {28'd0, q},  e.q);
        check("nq",    e.idx, {28'd0, nq}, (M - 1) - e.q);
        check("cout",  e.idx, {31'd0, cout}, e.cout);
        check("wrap",  e.idx, {31'd0, wrap}, e.wrap);
        check("casc_q", e.idx, {24'd0, hi_q, lo_q}, e.cq);
        check("casc_wrap", e.idx, {31'd0, hi_wrap}, e.cwrap);
      end
    end
  end

  // One cycle: drive inputs just after a rising edge, record what must be
  // visible before the next edge, then advance the reference on that edge.
  task automatic step(input int rn, input int e_, input int m_, input int c_,
                      input int dv, input int dh, input int si, input int sr);
    exp_t x;
    int c0, lc, hc;
    nreset = rn[0]; en = e_[0]; mode = m_[2:0]; cin = c_[0];
    d = dv[W-1:0]; d_hi = dh[W-1:0]; sil = si[0]; sir = sr[0];
    if (rn == 0) begin
      mq = 0; mw = 0; mlo = 0; mhi = 0; mhw = 0;
    end
    c0 = cfun(mq, m_, c_, rn);
    lc = cfun(mlo, m_, c_, rn);
    hc = cfun(mhi, m_, lc, rn);
    x.idx = n_step; x.q = mq; x.cout = c0; x.wrap = mw;
    x.cq = mhi * M + mlo; x.cwrap = mhw;
    sb.push_back(x);
    n_step++;
    @(posedge clk);
    if (rn != 0) begin
      mw  = (e_ != 0 && c0 != 0) ? 1 : 0;
      mhw = (e_ != 0 && hc != 0) ? 1 : 0;
      if (e_ != 0) begin
        mq  = nxt(mq, m_, c_, dv, si, sr);
        mlo = nxt(mlo, m_, c_, dv, si, sr);
        mhi = nxt(mhi, m_, lc, dh, si, sr);
      end
    end
    #1;
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    @(posedge clk); #1;
    // reset state
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 2, 1, 0, 0, 0, 0);
    // reset mid-count
    step(1, 1, 3, 1, 9, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0, 0);
    // increment wrap
    step(1, 1, 3, 1, 14, 15, 0, 0);
    step(1, 1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0, 0);
    // decrement through the cascade, then hold with cin low
    step(1, 1, 3, 1, 0, 0, 0, 0);
    step(1, 1, 2, 1, 0, 0, 0, 0);
    step(1, 1, 2, 0, 0, 0, 0, 0);
    step(1, 1, 2, 0, 0, 0, 0, 0);
    // shifts
    step(1, 1, 3, 1, 9, 9, 0, 0);
    step(1, 1, 4, 1, 0, 0, 1, 0);
    step(1, 1, 5, 1, 0, 0, 0, 1);
    step(1, 1, 6, 1, 0, 0, 0, 0);
    step(1, 1, 7, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0, 0);
    // enable gating
    step(1, 1, 3, 1, 15, 15, 0, 0);
    step(1, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0, 0);
    // cin gating
    step(1, 1, 3, 1, 15, 15, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 3, 0, 5, 10, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0) ? 1 : 0,
           ($urandom_range(0, 7) != 0) ? 1 : 0,
           int'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0) ? 1 : 0,
           int'($urandom_range(0, M - 1)),
           int'($urandom_range(0, M - 1)),
           int'($urandom_range(0, 1)),
           int'($urandom_range(0, 1)));
    end
    step(1, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
